// File: rtl/jtframe_sub_bridge.sv
// Main/sub CPU glue around a shared dual-port RAM: it stretches the sub reset, latches the NMI,
// and runs a bus request/grant FSM that gates main-side writes.
module jtframe_sub_bridge #(
   parameter int unsigned AW     = 10,
   parameter int unsigned MAW    = 9,
   parameter int unsigned RSTLEN = 15,
   parameter int unsigned MODE   = 0,
   parameter int unsigned TOUT   = 1023
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cen,
   input  logic           main_cen,
   input  logic           sub_rstb,
   input  logic [MAW-1:0] main_addr,
   input  logic           main_wrn,
   input  logic [7:0]     main_din,
   input  logic           main_cs,
   output logic [7:0]     main_dout,
   input  logic           halt_req,
   input  logic           nmi_set,
   output logic           sub_rstn,
   output logic           sub_busrq_n,
   input  logic           sub_busak_n,
   output logic           sub_nmi_n,
   input  logic [AW-1:0]  sub_addr,
   input  logic           sub_wrn,
   input  logic [7:0]     sub_din,
   input  logic           sub_cs,
   input  logic           sub_nmi_ack,
   output logic [7:0]     sub_dout,
   output logic           granted,
   output logic           timeout
);

   localparam int unsigned TW = (TOUT > 1) ? $clog2(TOUT + 1) : 1;

   typedef enum logic [1:0] {StRun, StReq, StGrant, StRelease} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            timeout_q, timeout_d;
   logic [7:0]      rcnt_q;
   logic            sub_rstn_q;
   logic            nmi_last_q, nmi_q;
   logic            mwe_q, swe_q, swrn_last_q;
   logic [AW-1:0]   maddr_q, saddr_q, main_addr_ext;
   logic [7:0]      mdin_q, sdin_q;
   logic [7:0]      mem [0:(1<<AW)-1];

   assign main_addr_ext = AW'(main_addr);
   assign sub_rstn      = sub_rstn_q;
   assign sub_nmi_n     = ~nmi_q;
   assign timeout       = timeout_q;

   // Reset stretcher: release the sub CPU RSTLEN+1 cen ticks after rst/sub_rstb go away
   always_ff @(posedge clk) begin
      if (rst || !sub_rstb) begin
         rcnt_q     <= 8'(RSTLEN);
         sub_rstn_q <= 1'b0;
      end else if (cen) begin
         if (rcnt_q != 8'd0) rcnt_q <= rcnt_q - 8'd1;
         else                sub_rstn_q <= 1'b1;
      end
   end

   // NMI latch: set on nmi_set rising edge, clear (dominant) on ack or while sub is in reset
   always_ff @(posedge clk) begin
      if (rst) begin
         nmi_last_q <= 1'b0;
         nmi_q      <= 1'b0;
      end else begin
         nmi_last_q <= nmi_set;
         if (!sub_rstn_q || sub_nmi_ack) nmi_q <= 1'b0;
         else if (nmi_set && !nmi_last_q) nmi_q <= 1'b1;
      end
   end

   // Bus arbitration state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Bus arbitration next state, REQ watchdog and bus outputs
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      timeout_d   = timeout_q;
      sub_busrq_n = 1'b1;
      granted     = 1'b0;
      unique case (state_q)
         StRun: begin
            if (halt_req) state_d = StReq;
         end
         StReq: begin
            sub_busrq_n = 1'b0;
            if (!sub_busak_n)  state_d = StGrant;
            else if (!halt_req) state_d = StRun;
            else if (cen && TOUT != 0 && !timeout_q) begin
               if (tcnt_q == TW'(TOUT - 1)) timeout_d = 1'b1;
               else                         tcnt_d    = tcnt_q + TW'(1);
            end
         end
         StGrant: begin
            sub_busrq_n = 1'b0;
            granted     = 1'b1;
            if (!halt_req)        state_d = StRelease;
            else if (sub_busak_n) state_d = StReq;
         end
         StRelease: begin
            if (sub_busak_n)   state_d = StRun;
            else if (halt_req) state_d = StReq;
         end
         default: state_d = StRun;
      endcase
      // The watchdog only measures one uninterrupted REQ stay
      if (state_q != StReq) tcnt_d = '0;
      if (!halt_req) timeout_d = 1'b0;
      if (!sub_rstn_q) begin
         state_d = StRun;
         tcnt_d  = '0;
      end
   end

   // Write capture: main on main_cen (gated by grant unless MODE 1), sub on wrn falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         mwe_q       <= 1'b0;
         swe_q       <= 1'b0;
         swrn_last_q <= 1'b1;
      end else begin
         mwe_q       <= main_cen & ~main_wrn & main_cs & (granted | (MODE == 1));
         swe_q       <= sub_cs & ~sub_wrn & swrn_last_q;
         swrn_last_q <= sub_wrn;
      end
      if (main_cen) begin
         maddr_q <= main_addr_ext;
         mdin_q  <= main_din;
      end
      saddr_q <= sub_addr;
      sdin_q  <= sub_din;
   end

   // Shared RAM; the main write is issued last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (swe_q) mem[saddr_q] <= sdin_q;
      if (mwe_q) mem[maddr_q] <= mdin_q;
      sub_dout  <= mem[sub_addr];
      main_dout <= mem[main_addr_ext];
   end

endmodule

// File: tb/tb_jtframe_sub_bridge.sv
// Self-checking bench for jtframe_sub_bridge: reset stretch, NMI latch, bus FSM, shared RAM.
module tb_jtframe_sub_bridge;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst, cen, main_cen, sub_rstb;
   logic [AW-1:0] main_addr, sub_addr;
   logic          main_wrn, main_cs, sub_wrn, sub_cs;
   logic [7:0]    main_din, sub_din, main_dout, sub_dout;
   logic          halt_req, nmi_set, sub_rstn, sub_busrq_n, sub_busak_n, sub_nmi_n;
   logic          sub_nmi_ack, granted, timeout;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_cen   = 0;
   int            cc      = 0;
   logic [7:0]    model [0:(1<<AW)-1];
   string         sb_tag[$];
   logic [7:0]    sb_val[$];

   jtframe_sub_bridge #(
      .AW     (AW),
      .MAW    (AW),
      .RSTLEN (15),
      .MODE   (0),
      .TOUT   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cen         (cen),
      .main_cen    (main_cen),
      .sub_rstb    (sub_rstb),
      .main_addr   (main_addr),
      .main_wrn    (main_wrn),
      .main_din    (main_din),
      .main_cs     (main_cs),
      .main_dout   (main_dout),
      .halt_req    (halt_req),
      .nmi_set     (nmi_set),
      .sub_rstn    (sub_rstn),
      .sub_busrq_n (sub_busrq_n),
      .sub_busak_n (sub_busak_n),
      .sub_nmi_n   (sub_nmi_n),
      .sub_addr    (sub_addr),
      .sub_wrn     (sub_wrn),
      .sub_din     (sub_din),
      .sub_cs      (sub_cs),
      .sub_nmi_ack (sub_nmi_ack),
      .sub_dout    (sub_dout),
      .granted     (granted),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // cen high for one clk out of every four
   initial begin
      cen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cc  = cc + 1;
         cen = (cc % 4 == 0);
      end
   end

   // Count the cen ticks the DUT sees
   always @(posedge clk) if (cen) n_cen <= n_cen + 1;

   initial begin
      #2000000;
      $display("FAIL global_watchdog: got hang expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Wait for the stretched reset to release; expect exactly 16 cen ticks
   task automatic wait_rstn(input string tag);
      int start;
      bit seen;
      start = n_cen;
      seen  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         clk1();
         if (i == 5) begin
            chk({tag, "_busrq_in_rst"}, sub_busrq_n, 1);
            chk({tag, "_nmi_in_rst"}, sub_nmi_n, 1);
         end
         if (sub_rstn) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_released"}, seen, 1);
      chk({tag, "_cens"}, n_cen - start, 16);
   endtask

   task automatic sub_write(input logic [AW-1:0] a, input logic [7:0] d);
      sub_addr = a; sub_din = d; sub_cs = 1'b1; sub_wrn = 1'b0;
      clk1();
      sub_cs = 1'b0; sub_wrn = 1'b1;
      clk1();
      model[a] = d;
   endtask

   task automatic main_write(input logic [AW-1:0] a, input logic [7:0] d, input bit takes);
      main_addr = a; main_din = d; main_cs = 1'b1; main_wrn = 1'b0;
      clk1();
      main_cs = 1'b0; main_wrn = 1'b1;
      clk1();
      if (takes) model[a] = d;
   endtask

   // Scoreboard read: expectation queued at issue, popped when read data appears
   task automatic rd(input bit main_port, input logic [AW-1:0] a, input string tag);
      string t;
      logic [7:0] v;
      if (main_port) main_addr = a;
      else           sub_addr  = a;
      sb_tag.push_back(tag);
      sb_val.push_back(model[a]);
      clk1();
      t = sb_tag.pop_front();
      v = sb_val.pop_front();
      chk(t, main_port ? main_dout : sub_dout, v);
   endtask

   initial begin
      int start;
      bit seen;
      rst = 1'b1; sub_rstb = 1'b1; main_cen = 1'b1;
      main_addr = '0; main_wrn = 1'b1; main_din = '0; main_cs = 1'b0;
      sub_addr = '0; sub_wrn = 1'b1; sub_din = '0; sub_cs = 1'b0;
      halt_req = 1'b0; nmi_set = 1'b0; sub_busak_n = 1'b1; sub_nmi_ack = 1'b0;
      clk1();
      clk1();
      chk("rst_sub_rstn", sub_rstn, 0);
      chk("rst_busrq_n", sub_busrq_n, 1);
      chk("rst_nmi_n", sub_nmi_n, 1);
      chk("rst_granted", granted, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b0;
      wait_rstn("stretch_rst");

      // NMI latch
      nmi_set = 1'b1;
      clk1();
      chk("nmi_set", sub_nmi_n, 0);
      nmi_set = 1'b0;
      clk1();
      chk("nmi_hold", sub_nmi_n, 0);
      sub_nmi_ack = 1'b1;
      clk1();
      chk("nmi_ack", sub_nmi_n, 1);
      sub_nmi_ack = 1'b0;
      nmi_set = 1'b1; sub_nmi_ack = 1'b1;
      clk1();
      chk("nmi_set_ack_same", sub_nmi_n, 1);
      nmi_set = 1'b0; sub_nmi_ack = 1'b0;
      clk1();
      chk("nmi_set_ack_after", sub_nmi_n, 1);

      // NMI pending, then sub reset request with halt_req held: both must be overridden
      nmi_set = 1'b1;
      clk1();
      nmi_set = 1'b0;
      sub_rstb = 1'b0;
      clk1();
      sub_rstb = 1'b1; halt_req = 1'b1;
      wait_rstn("stretch_rstb");
      clk1();
      chk("req_after_rst", sub_busrq_n, 0);
      halt_req = 1'b0;
      clk1();
      chk("run_after_drop", sub_busrq_n, 1);

      // Ungranted main write must be dropped in MODE 0
      sub_write(10'h012, 8'hA5);
      main_write(10'h012, 8'h5A, 1'b0);
      rd(1'b0, 10'h012, "sub_rd_ungranted");
      rd(1'b1, 10'h012, "main_rd_ungranted");

      // Request, late ack, grant
      halt_req = 1'b1;
      clk1();
      chk("req_busrq_n", sub_busrq_n, 0);
      chk("req_granted", granted, 0);
      clk1();
      clk1();
      chk("req_wait_granted", granted, 0);
      sub_busak_n = 1'b0;
      clk1();
      chk("grant_granted", granted, 1);
      chk("grant_busrq_n", sub_busrq_n, 0);

      main_write(10'h012, 8'h5A, 1'b1);
      rd(1'b0, 10'h012, "sub_rd_granted");

      // Same-clk collision at top address: main wins
      sub_addr = 10'h3FF; sub_din = 8'h11; sub_cs = 1'b1; sub_wrn = 1'b0;
      main_addr = 10'h3FF; main_din = 8'h22; main_cs = 1'b1; main_wrn = 1'b0;
      clk1();
      sub_cs = 1'b0; sub_wrn = 1'b1; main_cs = 1'b0; main_wrn = 1'b1;
      clk1();
      model[10'h3FF] = 8'h22;
      rd(1'b0, 10'h3FF, "sub_rd_collision");
      rd(1'b1, 10'h3FF, "main_rd_collision");

      // Lost ack drops back to REQ, then re-grant
      sub_busak_n = 1'b1;
      clk1();
      chk("lost_ack_granted", granted, 0);
      chk("lost_ack_busrq_n", sub_busrq_n, 0);
      sub_busak_n = 1'b0;
      clk1();
      chk("regrant", granted, 1);

      // Release: bus request drops, writes blocked, wait for ack to go away
      halt_req = 1'b0;
      clk1();
      chk("release_granted", granted, 0);
      chk("release_busrq_n", sub_busrq_n, 1);
      main_write(10'h012, 8'h77, 1'b0);
      rd(1'b0, 10'h012, "sub_rd_release");
      sub_busak_n = 1'b1;
      clk1();
      halt_req = 1'b1;
      clk1();
      chk("run_then_req", sub_busrq_n, 0);

      // Watchdog: no ack while in REQ for 8 cen ticks
      start = n_cen;
      seen  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         clk1();
         if (timeout) begin
            seen = 1'b1;
            break;
         end
      end
      chk("timeout_seen", seen, 1);
      chk("timeout_cens", n_cen - start, 8);
      repeat (6) clk1();
      chk("timeout_sticky", timeout, 1);
      chk("timeout_stay_req", sub_busrq_n, 0);
      halt_req = 1'b0;
      clk1();
      chk("timeout_clear", timeout, 0);
      chk("timeout_run", sub_busrq_n, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
